dmem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory request interface (read/write/address/in_data in;
//  out_addr/out_data/valid/ready out). Models a single-outstanding, fixed-latency word-addressed data

---
 rtl/dmem_responder_pkg.sv | 24 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state encoding, request op
// encoding, and the latency counter width.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Wide enough for the largest legal LATENCY (255).
    localparam int COUNT_BITS = 8;

    // A request with write high is a write whatever read says.
    function automatic op_e decode_op(input logic write);
        return write ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with write-first registered output. The output
// register only changes when en is high, so it holds the last access result.
module dmem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_BITS)-1];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge clock) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding data-memory responder. One request is accepted
// while ready; a one-cycle valid pulse returns LATENCY cycles after the accept edge.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH_BITS   = 10,
    parameter int LATENCY      = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [ADDRESS_BITS-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    valid,
    output logic                    ready,
    input  logic                    report
);

    // BUSY lasts LATENCY-1 cycles; the count reaching zero moves to RESP.
    localparam logic [COUNT_BITS-1:0] COUNT_LOAD =
        (LATENCY > 1) ? COUNT_BITS'(LATENCY - 2) : '0;
    localparam bit DIRECT = (LATENCY == 1);

    state_e                  state, state_next;
    logic [COUNT_BITS-1:0]   count, count_next;
    logic [ADDRESS_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    op_e                     op_q;
    logic [31:0]             cycle_count;

    logic                    accept;
    logic                    fire;
    logic [ADDRESS_BITS-1:0] acc_addr;
    logic [DATA_WIDTH-1:0]   acc_data;
    op_e                     acc_op;

    assign ready  = (state == ST_IDLE) || (state == ST_RESP);
    assign valid  = (state == ST_RESP);
    assign accept = ready && (read || write);

    // With LATENCY=1 the access happens on the accept edge itself, before anything is latched.
    assign acc_addr = DIRECT ? address : addr_q;
    assign acc_data = DIRECT ? in_data : data_q;
    assign acc_op   = DIRECT ? decode_op(write) : op_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        fire       = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (state == ST_RESP) begin
                    state_next = ST_IDLE;
                end
                if (accept) begin
                    if (DIRECT) begin
                        state_next = ST_RESP;
                        fire       = 1'b1;
                    end else begin
                        state_next = ST_BUSY;
                        count_next = COUNT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (count == '0) begin
                    state_next = ST_RESP;
                    fire       = 1'b1;
                end else begin
                    count_next = count - COUNT_BITS'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            op_q        <= OP_READ;
            out_addr    <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            cycle_count <= cycle_count + 32'd1;
            if (accept) begin
                addr_q <= address;
                data_q <= in_data;
                op_q   <= decode_op(write);
            end
            if (fire) begin
                out_addr <= acc_addr;
            end
        end
    end

    // The write commits, and read data is captured, on the edge entering RESP.
    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .en    (fire),
        .we    (fire && (acc_op == OP_WRITE)),
        .addr  (acc_addr[DEPTH_BITS-1:0]),
        .wdata (acc_data),
        .q     (out_data)
    );

    // The report printout is a simulation-only feature; in hardware its inputs are only sunk.
    logic unused_report;
    assign unused_report = report ^ (^cycle_count) ^ (CORE != 0);

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 1, 2, 3) are
// checked against a word-array reference model with timing derived from LATENCY.
module tb_dmem_responder;

    logic              clock = 1'b0;
    logic              reset;
    logic [2:0]        rd_s, wr_s;
    logic [2:0][19:0]  addr_s, oaddr_s;
    logic [2:0][31:0]  wdat_s, odat_s;
    logic [2:0]        valid_s, ready_s;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [3][1024];
    bit          known [3][1024];

    always #5 clock = ~clock;

    // Instance d has LATENCY d+1.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .CORE         (g),
            .DATA_WIDTH   (32),
            .ADDRESS_BITS (20),
            .DEPTH_BITS   (10),
            .LATENCY      (g + 1)
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .read     (rd_s[g]),
            .write    (wr_s[g]),
            .address  (addr_s[g]),
            .in_data  (wdat_s[g]),
            .out_addr (oaddr_s[g]),
            .out_data (odat_s[g]),
            .valid    (valid_s[g]),
            .ready    (ready_s[g]),
            .report   (1'b0)
        );
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete request on instance d, with its own timing and data comparisons.
    task automatic txn(input int d, input logic rd, input logic wr,
                       input logic [19:0] a, input logic [31:0] wd);
        logic [31:0] exp_d;
        int idx;
        int n;
        bit got;
        idx = int'(a[9:0]);
        @(negedge clock);
        rd_s[d] = rd; wr_s[d] = wr; addr_s[d] = a; wdat_s[d] = wd;
        checks++;
        if (ready_s[d] !== 1'b1) begin
            errors++; $display("FAIL txn_ready_idle d=%0d got %b want 1", d, ready_s[d]);
        end
        if (wr) begin
            model[d][idx] = wd; known[d][idx] = 1'b1; exp_d = wd;
        end else begin
            exp_d = model[d][idx];
        end
        @(posedge clock);
        #1;
        rd_s[d] = 1'b0; wr_s[d] = 1'b0;
        got = 1'b0; n = 0;
        while (!got && n < 300) begin
            @(negedge clock);
            n++;
            if (valid_s[d] === 1'b1) begin
                got = 1'b1;
            end else begin
                checks++;
                if (ready_s[d] !== 1'b0) begin
                    errors++; $display("FAIL txn_ready_busy d=%0d cycle %0d got %b want 0", d, n, ready_s[d]);
                end
            end
        end
        checks++;
        if (!got || n != d + 1) begin
            errors++; $display("FAIL txn_latency d=%0d got %0d (seen=%0b) want %0d", d, n, got, d + 1);
        end
        checks++;
        if (oaddr_s[d] !== a) begin
            errors++; $display("FAIL txn_out_addr d=%0d got %h want %h", d, oaddr_s[d], a);
        end
        checks++;
        if (odat_s[d] !== exp_d) begin
            errors++; $display("FAIL txn_out_data d=%0d addr %h got %h want %h", d, a, odat_s[d], exp_d);
        end
        @(negedge clock);
        checks++;
        if (valid_s[d] !== 1'b0 || ready_s[d] !== 1'b1) begin
            errors++; $display("FAIL txn_after_pulse d=%0d valid %b ready %b want 0/1", d, valid_s[d], ready_s[d]);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready_s[d] !== 1'b1 || valid_s[d] !== 1'b0) begin
                errors++; $display("FAIL %s_handshake d=%0d ready %b valid %b want 1/0", tag, d, ready_s[d], valid_s[d]);
            end
            checks++;
            if (oaddr_s[d] !== 20'h0 || odat_s[d] !== 32'h0) begin
                errors++; $display("FAIL %s_outputs d=%0d out_addr %h out_data %h want 0/0", tag, d, oaddr_s[d], odat_s[d]);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rd_s = '0; wr_s = '0; addr_s = '0; wdat_s = '0;
        repeat (3) @(negedge clock);
        check_reset_state("reset_init");
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_busy;
        txn(1, 1'b0, 1'b1, 20'h00050, 32'h22222222);
        @(negedge clock);
        wr_s[1] = 1'b1; addr_s[1] = 20'h00050; wdat_s[1] = 32'h33333333;
        @(posedge clock);
        #1;
        wr_s[1] = 1'b0;
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_reset_state("reset_busy");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (valid_s[1] !== 1'b0) begin
                errors++; $display("FAIL reset_abort_valid cycle %0d got %b want 0", i, valid_s[1]);
            end
        end
        // The aborted write must not have landed.
        txn(1, 1'b1, 1'b0, 20'h00050, 32'h0);
    endtask

    task automatic test_write_read;
        txn(1, 1'b0, 1'b1, 20'h00010, 32'hDEADBEEF);
        txn(1, 1'b1, 1'b0, 20'h00010, 32'h0);
    endtask

    task automatic test_read_write_both;
        txn(1, 1'b1, 1'b1, 20'h00004, 32'h12345678);
        txn(1, 1'b1, 1'b0, 20'h00004, 32'h0);
    endtask

    task automatic test_wrap;
        txn(1, 1'b0, 1'b1, 20'h00401, 32'hA5A5A5A5);
        txn(1, 1'b1, 1'b0, 20'h00001, 32'h0);
    endtask

    task automatic test_latency1;
        txn(0, 1'b0, 1'b1, 20'h00123, 32'hCAFEF00D);
        txn(0, 1'b1, 1'b0, 20'h00123, 32'h0);
        txn(0, 1'b1, 1'b0, 20'h00123, 32'h0);
    endtask

    // Requests changing while the responder is busy must be ignored.
    task automatic test_ignore_busy;
        txn(1, 1'b0, 1'b1, 20'h00200, 32'h0BADF00D);
        @(negedge clock);
        wr_s[1] = 1'b1; addr_s[1] = 20'h00300; wdat_s[1] = 32'h11112222;
        @(posedge clock);
        #1;
        addr_s[1] = 20'h00200; wdat_s[1] = 32'h99998888;
        @(negedge clock);
        checks++;
        if (ready_s[1] !== 1'b0 || valid_s[1] !== 1'b0) begin
            errors++; $display("FAIL ignore_busy_state ready %b valid %b want 0/0", ready_s[1], valid_s[1]);
        end
        @(negedge clock);
        wr_s[1] = 1'b0;
        model[1][10'h300] = 32'h11112222; known[1][10'h300] = 1'b1;
        checks++;
        if (valid_s[1] !== 1'b1 || oaddr_s[1] !== 20'h00300 || odat_s[1] !== 32'h11112222) begin
            errors++; $display("FAIL ignore_busy_resp valid %b addr %h data %h want 1/00300/11112222",
                               valid_s[1], oaddr_s[1], odat_s[1]);
        end
        txn(1, 1'b1, 1'b0, 20'h00200, 32'h0);
        txn(1, 1'b1, 1'b0, 20'h00300, 32'h0);
    endtask

    // read held high on the LATENCY=3 instance: accepts every 3 cycles, pulses 2 cycles after each.
    task automatic test_back_to_back;
        logic [19:0] addrs [4];
        int pulses;
        bit exp_v;
        for (int k = 0; k < 4; k++) begin
            addrs[k] = 20'($urandom);
            addrs[k][9:0] = 10'(k * 37 + 5);
            txn(2, 1'b0, 1'b1, addrs[k], $urandom);
        end
        pulses = 0;
        @(negedge clock);
        rd_s[2] = 1'b1; wr_s[2] = 1'b0; addr_s[2] = addrs[0];
        for (int c = 0; c < 12; c++) begin
            @(posedge clock);
            @(negedge clock);
            exp_v = (c % 3 == 2);
            if (valid_s[2] === 1'b1) pulses++;
            checks++;
            if (valid_s[2] !== exp_v || ready_s[2] !== exp_v) begin
                errors++; $display("FAIL b2b_timing cycle %0d valid %b ready %b want %b", c, valid_s[2], ready_s[2], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (oaddr_s[2] !== addrs[c/3] || odat_s[2] !== model[2][int'(addrs[c/3][9:0])]) begin
                    errors++; $display("FAIL b2b_data cycle %0d addr %h data %h want %h/%h", c, oaddr_s[2], odat_s[2],
                                       addrs[c/3], model[2][int'(addrs[c/3][9:0])]);
                end
            end
            if (c % 3 == 0 && c / 3 + 1 < 4) addr_s[2] = addrs[c/3 + 1];
            if (c == 11) rd_s[2] = 1'b0;
        end
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL b2b_pulse_count got %0d want 4", pulses);
        end
        @(negedge clock);
        checks++;
        if (valid_s[2] !== 1'b0) begin
            errors++; $display("FAIL b2b_idle valid %b want 0", valid_s[2]);
        end
    endtask

    task automatic test_random;
        logic [19:0] pool [8];
        logic [19:0] a;
        logic rd, wr;
        for (int i = 0; i < 8; i++) pool[i] = 20'($urandom);
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 30; t++) begin
                a  = pool[$urandom_range(0, 7)];
                wr = !known[d][int'(a[9:0])] || ($urandom_range(0, 2) == 0);
                rd = !wr || ($urandom_range(0, 1) == 1);
                txn(d, rd, wr, a, $urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_write_both();
        test_wrap();
        test_latency1();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
